// File: rtl/frame_capture_writer_if.sv
// Frame-buffer capture bus: display-side pixel stream in, RGB565 frame-buffer writes out.
interface frame_capture_writer_if #(
  parameter int ADDR_W = 17
);
  logic              pclk;
  logic              DE;
  logic [9:0]        x_pixel;
  logic [9:0]        y_pixel;
  logic [3:0]        r_in;
  logic [3:0]        g_in;
  logic [3:0]        b_in;
  logic              save_req;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              busy;
  logic              done;
  logic [7:0]        frame_saved_cnt;

  modport slave (
    input  pclk, DE, x_pixel, y_pixel, r_in, g_in, b_in, save_req,
    output wr_en, wr_addr, wr_data, busy, done, frame_saved_cnt
  );

  modport master (
    output pclk, DE, x_pixel, y_pixel, r_in, g_in, b_in, save_req,
    input  wr_en, wr_addr, wr_data, busy, done, frame_saved_cnt
  );
endinterface

// File: rtl/frame_capture_writer.sv
// Snapshots one displayed 640x480 RGB444 frame, decimated 2:1 per axis, into a
// 320x240 RGB565 frame buffer using the image reader's address map.
module frame_capture_writer #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 reset,
  frame_capture_writer_if.slave fb
);
  localparam int unsigned NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned CNT_W = $clog2(NPIX + 1);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              sample, origin, issue;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q, xh, yh, row_base, addr_calc;
  logic [15:0]       wr_data_q;
  logic [7:0]        saved_q;

  assign sample = fb.pclk & fb.DE & ~fb.x_pixel[0] & ~fb.y_pixel[0];
  assign origin = fb.pclk & fb.DE & (fb.x_pixel == '0) & (fb.y_pixel == '0);

  // Full-size buffer uses the shift-add row base (y*320 = y*256 + y*64).
  assign xh        = ADDR_W'(fb.x_pixel[9:1]);
  assign yh        = ADDR_W'(fb.y_pixel[9:1]);
  assign row_base  = (IMG_WIDTH == 320) ? (yh << 8) + (yh << 6)
                                        : yh * ADDR_W'(IMG_WIDTH);
  assign addr_calc = row_base + xh;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      saved_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == DONE) saved_q <= saved_q + 8'd1;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    issue      = 1'b0;
    case (state)
      IDLE: if (fb.save_req) state_next = ARM;
      ARM: begin
        if (origin) begin
          issue      = 1'b1;
          cnt_next   = CNT_W'(1);
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (sample) begin
          issue = 1'b1;
          // A fresh origin mid-capture restarts the count with (0,0) as write 1.
          cnt_next = origin ? CNT_W'(1) : cnt + 1'b1;
          if (cnt_next == CNT_W'(NPIX)) state_next = DONE;
        end
      end
      DONE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fb.busy = (state != IDLE);
    fb.done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= issue;
      if (issue) begin
        wr_addr_q <= addr_calc;
        wr_data_q <= {fb.r_in, fb.r_in[3], fb.g_in, fb.g_in[3:2], fb.b_in, fb.b_in[3]};
      end
    end
  end

  assign fb.wr_en           = wr_en_q;
  assign fb.wr_addr         = wr_addr_q;
  assign fb.wr_data         = wr_data_q;
  assign fb.frame_saved_cnt = saved_q;
endmodule

// File: tb/tb_frame_capture_writer.sv
// Directed bench: a 4x3 buffer instance (8x6 display) for whole-frame behaviour and
// a full-size instance for the 320-wide address map and RGB565 packing.
module tb_frame_capture_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_capture_writer_if #(.ADDR_W(4))  vs ();
  frame_capture_writer_if #(.ADDR_W(17)) vb ();

  frame_capture_writer #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .ADDR_W(4)) dut_s (
    .clk(clk), .reset(reset), .fb(vs.slave));
  frame_capture_writer dut_b (
    .clk(clk), .reset(reset), .fb(vb.slave));

  int total = 0;
  int bad = 0;

  int         n_wr, n_done, done_addr;
  bit         done_with_wr;
  logic [3:0] addr_seq [0:63];
  logic [15:0] mem [0:15];

  always @(negedge clk) begin
    if (vs.wr_en) begin
      if (n_wr < 64) addr_seq[n_wr] = vs.wr_addr;
      mem[vs.wr_addr] = vs.wr_data;
      n_wr++;
    end
    if (vs.done) begin
      n_done++;
      done_with_wr = vs.wr_en;
      done_addr = int'(vs.wr_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_wr = 0; n_done = 0; done_with_wr = 1'b0; done_addr = -1;
  endtask

  task automatic pulse_save();
    vs.save_req = 1'b1;
    step();
    vs.save_req = 1'b0;
  endtask

  // Pixel colour encodes position: r = x[3:0], g = y[3:0], b = 4'hA.
  task automatic drive_pix(input int x, input int y, input bit de, input bit save, input bit gap);
    vs.pclk = 1'b1; vs.DE = de;
    vs.x_pixel = 10'(x); vs.y_pixel = 10'(y);
    vs.r_in = 4'(x); vs.g_in = 4'(y); vs.b_in = 4'hA;
    vs.save_req = save;
    step();
    vs.pclk = 1'b0; vs.save_req = 1'b0;
    if (gap) step();
  endtask

  // 8x6 active area, two blanking pixels per line, one blanking line (row 6).
  task automatic drive_frame(input int sx, input int sy, input int nrows, input bit gap);
    for (int y = 0; y < nrows; y++)
      for (int x = 0; x < 10; x++)
        drive_pix(x, y, (x < 8) && (y < 6), (x == sx) && (y == sy), gap);
  endtask

  task automatic drive_big(input int x, input int y, input bit de,
                           input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    vb.pclk = 1'b1; vb.DE = de;
    vb.x_pixel = 10'(x); vb.y_pixel = 10'(y);
    vb.r_in = r; vb.g_in = g; vb.b_in = b;
    step();
    vb.pclk = 1'b0;
  endtask

  function automatic logic [15:0] rgb565(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    return {r, r[3], g, g[3:2], b, b[3]};
  endfunction

  task automatic test_reset();
    reset = 1'b1; step(); step();
    total++; if (vs.wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %0b want 0", vs.wr_en); end
    total++; if (vs.wr_addr !== 4'd0) begin bad++; $display("FAIL rst_wr_addr: got %0h want 0", vs.wr_addr); end
    total++; if (vs.wr_data !== 16'h0) begin bad++; $display("FAIL rst_wr_data: got %0h want 0", vs.wr_data); end
    total++; if (vs.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", vs.busy); end
    total++; if (vs.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", vs.done); end
    total++; if (vs.frame_saved_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", vs.frame_saved_cnt); end
    reset = 1'b0; step();
  endtask

  task automatic test_full_frame();
    logic [15:0] exp_d;
    clear_mon();
    pulse_save();
    total++; if (vs.busy !== 1'b1) begin bad++; $display("FAIL armed_busy: got %0b want 1", vs.busy); end
    drive_frame(-1, -1, 7, 1'b1);
    total++; if (n_wr !== 12) begin bad++; $display("FAIL full_writes: got %0d want 12", n_wr); end
    total++; if (addr_seq[0] !== 4'd0) begin bad++; $display("FAIL first_addr: got %0d want 0", addr_seq[0]); end
    total++; if (addr_seq[1] !== 4'd1) begin bad++; $display("FAIL px_2_0_addr: got %0d want 1", addr_seq[1]); end
    total++; if (addr_seq[4] !== 4'd4) begin bad++; $display("FAIL px_0_2_addr: got %0d want 4", addr_seq[4]); end
    total++; if (addr_seq[11] !== 4'd11) begin bad++; $display("FAIL last_addr: got %0d want 11", addr_seq[11]); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL full_done_cnt: got %0d want 1", n_done); end
    total++; if (done_with_wr !== 1'b1 || done_addr !== 11) begin bad++; $display("FAIL done_timing: got wr=%0b addr=%0d want wr=1 addr=11", done_with_wr, done_addr); end
    total++; if (vs.frame_saved_cnt !== 8'd1) begin bad++; $display("FAIL full_saved_cnt: got %0d want 1", vs.frame_saved_cnt); end
    total++; if (vs.busy !== 1'b0) begin bad++; $display("FAIL full_idle_busy: got %0b want 0", vs.busy); end
    for (int a = 0; a < 12; a++) begin
      exp_d = rgb565(4'(2 * (a % 4)), 4'(2 * (a / 4)), 4'hA);
      total++; if (mem[a] !== exp_d) begin bad++; $display("FAIL pix_data[%0d]: got %0h want %0h", a, mem[a], exp_d); end
    end
  endtask

  task automatic test_rgb_and_map();
    vb.save_req = 1'b1; step(); vb.save_req = 1'b0;
    drive_big(0, 0, 1'b1, 4'hF, 4'h8, 4'h1);
    total++; if (vb.wr_en !== 1'b1 || vb.wr_addr !== 17'd0) begin bad++; $display("FAIL big_origin: got en=%0b addr=%0d want en=1 addr=0", vb.wr_en, vb.wr_addr); end
    // {11111,100010,00010}
    total++; if (vb.wr_data !== 16'hFC42) begin bad++; $display("FAIL rgb_fc42: got %0h want fc42", vb.wr_data); end
    drive_big(1, 0, 1'b1, 4'h3, 4'h3, 4'h3);
    total++; if (vb.wr_en !== 1'b0) begin bad++; $display("FAIL odd_x_nowrite: got %0b want 0", vb.wr_en); end
    drive_big(2, 0, 1'b1, 4'h0, 4'h0, 4'h0);
    total++; if (vb.wr_en !== 1'b1 || vb.wr_addr !== 17'd1) begin bad++; $display("FAIL big_px_2_0: got en=%0b addr=%0d want en=1 addr=1", vb.wr_en, vb.wr_addr); end
    drive_big(4, 0, 1'b0, 4'h0, 4'h0, 4'h0);
    total++; if (vb.wr_en !== 1'b0 || vb.wr_addr !== 17'd1) begin bad++; $display("FAIL de0_hold: got en=%0b addr=%0d want en=0 addr=1", vb.wr_en, vb.wr_addr); end
    drive_big(0, 2, 1'b1, 4'h0, 4'h0, 4'h0);
    total++; if (vb.wr_addr !== 17'd320) begin bad++; $display("FAIL big_px_0_2: got %0d want 320", vb.wr_addr); end
    drive_big(4, 3, 1'b1, 4'h0, 4'h0, 4'h0);
    total++; if (vb.wr_en !== 1'b0) begin bad++; $display("FAIL odd_y_nowrite: got %0b want 0", vb.wr_en); end
    drive_big(638, 478, 1'b1, 4'h0, 4'h7, 4'hE);
    total++; if (vb.wr_addr !== 17'd76799) begin bad++; $display("FAIL big_last_addr: got %0d want 76799", vb.wr_addr); end
    // {00000,011101,11101}
    total++; if (vb.wr_data !== 16'h03BD) begin bad++; $display("FAIL rgb_03bd: got %0h want 03bd", vb.wr_data); end
  endtask

  task automatic test_mid_frame_save();
    clear_mon();
    drive_frame(0, 3, 7, 1'b1);
    total++; if (n_wr !== 0) begin bad++; $display("FAIL mid_save_early: got %0d want 0", n_wr); end
    total++; if (vs.busy !== 1'b1) begin bad++; $display("FAIL mid_save_armed: got %0b want 1", vs.busy); end
    drive_frame(-1, -1, 7, 1'b1);
    total++; if (n_wr !== 12 || n_done !== 1) begin bad++; $display("FAIL mid_save_frame: got wr=%0d done=%0d want wr=12 done=1", n_wr, n_done); end
    total++; if (vs.frame_saved_cnt !== 8'd2) begin bad++; $display("FAIL mid_save_cnt: got %0d want 2", vs.frame_saved_cnt); end
  endtask

  task automatic test_coincident_save();
    clear_mon();
    drive_frame(0, 0, 7, 1'b1);
    total++; if (n_wr !== 0) begin bad++; $display("FAIL coinc_early: got %0d want 0", n_wr); end
    drive_frame(-1, -1, 7, 1'b1);
    total++; if (n_wr !== 12 || addr_seq[0] !== 4'd0) begin bad++; $display("FAIL coinc_frame: got wr=%0d a0=%0d want wr=12 a0=0", n_wr, addr_seq[0]); end
    total++; if (vs.frame_saved_cnt !== 8'd3) begin bad++; $display("FAIL coinc_cnt: got %0d want 3", vs.frame_saved_cnt); end
  endtask

  task automatic test_second_save();
    clear_mon();
    pulse_save();
    drive_frame(4, 2, 7, 1'b1);
    total++; if (n_wr !== 12 || n_done !== 1) begin bad++; $display("FAIL dup_save_frame: got wr=%0d done=%0d want wr=12 done=1", n_wr, n_done); end
    total++; if (vs.frame_saved_cnt !== 8'd4) begin bad++; $display("FAIL dup_save_cnt: got %0d want 4", vs.frame_saved_cnt); end
    drive_frame(-1, -1, 7, 1'b0);
    total++; if (n_wr !== 12 || vs.busy !== 1'b0) begin bad++; $display("FAIL dup_not_queued: got wr=%0d busy=%0b want wr=12 busy=0", n_wr, vs.busy); end
  endtask

  task automatic test_restart();
    clear_mon();
    pulse_save();
    drive_frame(-1, -1, 3, 1'b1);
    total++; if (n_wr !== 8 || vs.busy !== 1'b1 || n_done !== 0) begin bad++; $display("FAIL partial: got wr=%0d busy=%0b done=%0d want 8/1/0", n_wr, vs.busy, n_done); end
    drive_frame(-1, -1, 7, 1'b1);
    total++; if (n_wr !== 20 || n_done !== 1) begin bad++; $display("FAIL restart_frame: got wr=%0d done=%0d want wr=20 done=1", n_wr, n_done); end
    total++; if (addr_seq[8] !== 4'd0 || addr_seq[19] !== 4'd11) begin bad++; $display("FAIL restart_addrs: got %0d,%0d want 0,11", addr_seq[8], addr_seq[19]); end
    total++; if (vs.frame_saved_cnt !== 8'd5) begin bad++; $display("FAIL restart_cnt: got %0d want 5", vs.frame_saved_cnt); end
  endtask

  task automatic test_reset_mid_capture();
    clear_mon();
    pulse_save();
    drive_frame(-1, -1, 3, 1'b1);
    drive_pix(0, 4, 1'b1, 1'b0, 1'b0);
    total++; if (vs.wr_en !== 1'b1) begin bad++; $display("FAIL pre_reset_wr: got %0b want 1", vs.wr_en); end
    reset = 1'b1; step();
    total++; if (vs.wr_en !== 1'b0 || vs.busy !== 1'b0 || vs.done !== 1'b0) begin bad++; $display("FAIL mid_reset: got en=%0b busy=%0b done=%0b want 0/0/0", vs.wr_en, vs.busy, vs.done); end
    total++; if (vs.frame_saved_cnt !== 8'd0 || vs.wr_addr !== 4'd0) begin bad++; $display("FAIL mid_reset_regs: got cnt=%0d addr=%0d want 0/0", vs.frame_saved_cnt, vs.wr_addr); end
    reset = 1'b0; step();
    clear_mon();
    pulse_save();
    drive_frame(-1, -1, 7, 1'b1);
    total++; if (n_wr !== 12 || n_done !== 1 || addr_seq[11] !== 4'd11) begin bad++; $display("FAIL post_reset_frame: got wr=%0d done=%0d last=%0d want 12/1/11", n_wr, n_done, addr_seq[11]); end
    total++; if (vs.frame_saved_cnt !== 8'd1) begin bad++; $display("FAIL post_reset_cnt: got %0d want 1", vs.frame_saved_cnt); end
  endtask

  task automatic test_back_to_back_wrap();
    clear_mon();
    for (int i = 0; i < 254; i++) begin
      pulse_save();
      drive_frame(-1, -1, 7, 1'b0);
    end
    total++; if (vs.frame_saved_cnt !== 8'd255 || n_done !== 254) begin bad++; $display("FAIL cnt_255: got cnt=%0d done=%0d want 255/254", vs.frame_saved_cnt, n_done); end
    pulse_save();
    drive_frame(-1, -1, 7, 1'b0);
    total++; if (vs.frame_saved_cnt !== 8'd0) begin bad++; $display("FAIL cnt_wrap: got %0d want 0", vs.frame_saved_cnt); end
    total++; if (n_wr !== 255 * 12) begin bad++; $display("FAIL wrap_writes: got %0d want %0d", n_wr, 255 * 12); end
  endtask

  initial begin
    vs.pclk = 1'b0; vs.DE = 1'b0; vs.x_pixel = '0; vs.y_pixel = '0;
    vs.r_in = '0; vs.g_in = '0; vs.b_in = '0; vs.save_req = 1'b0;
    vb.pclk = 1'b0; vb.DE = 1'b0; vb.x_pixel = '0; vb.y_pixel = '0;
    vb.r_in = '0; vb.g_in = '0; vb.b_in = '0; vb.save_req = 1'b0;
    clear_mon();
    test_reset();
    test_full_frame();
    test_rgb_and_map();
    test_mid_frame_save();
    test_coincident_save();
    test_second_save();
    test_restart();
    test_reset_mid_capture();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
